cmd_saver: RTL

//  Reads a TRS-80 memory range and emits it as a TRS-80 /CMD byte stream for upload to the HPS.

---
 rtl/trs_cmd_pkg.sv | 29 ++
 rtl/cmd_byte_pipe.sv | 42 ++++
 rtl/cmd_saver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/trs_cmd_pkg.sv
// Shared TRS-80 /CMD definitions used by cmd_saver and cmd_loader.
// Record type codes, saver FSM states and the load-record length byte encoding.
package trs_cmd_pkg;

    localparam logic [7:0] CMD_REC_LOAD = 8'h01;
    localparam logic [7:0] CMD_REC_XFER = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REC_TYPE,
        S_REC_LEN,
        S_REC_ALO,
        S_REC_AHI,
        S_RD_REQ,
        S_RD_WAIT,
        S_DATA,
        S_TRL_TYPE,
        S_TRL_LEN,
        S_TRL_LO,
        S_TRL_HI,
        S_FINISH
    } saver_state_t;

    // The length byte counts the two address bytes, so 254/255/256 data bytes encode as 00/01/02.
    function automatic logic [7:0] cmd_len_byte(input logic [7:0] n);
        return n + 8'd2;
    endfunction

endpackage

// File: rtl/cmd_byte_pipe.sv
// One-entry output register for the /CMD byte stream.
// Holds out_data/out_valid until out_valid & out_ready, and counts the file offset of each byte.
module cmd_byte_pipe (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  load_data,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic [23:0] out_addr,
    output logic        can_load
);

    logic fire;

    assign fire     = out_valid & out_ready;
    // A new byte may enter when the register is empty or its byte leaves this cycle.
    assign can_load = ~out_valid | out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_addr  <= 24'h000000;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
            if (clear) begin
                out_addr <= 24'h000000;
            end else if (fire) begin
                out_addr <= out_addr + 24'd1;
            end
        end
    end

endmodule

// File: rtl/cmd_saver.sv
// Reads a TRS-80 memory range and streams it out as a /CMD file:
// type-01 load records of up to BLOCK_MAX bytes followed by one type-02 transfer record.
module cmd_saver
    import trs_cmd_pkg::*;
#(
    parameter int BLOCK_MAX   = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  start_addr,
    input  logic [15:0]  end_addr,
    input  logic [15:0]  exec_addr,
    output logic [15:0]  mem_addr,
    output logic         mem_rd,
    input  logic [7:0]   mem_data,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [23:0]  out_addr,
    output logic         busy,
    output logic         done,
    output logic         error,
    output saver_state_t state
);

    localparam logic [16:0] BLK = 17'(BLOCK_MAX);
    localparam logic [2:0]  LAT = 3'(MEM_LATENCY);

    logic [15:0] cur;
    logic [15:0] exec;
    logic [16:0] rec_left;
    logic [16:0] total_left;
    logic [2:0]  lat_cnt;
    logic [7:0]  rd_byte;
    logic        can_load;
    logic        load;
    logic [7:0]  load_byte;
    logic        accept;

    assign accept = (state == S_IDLE) && start && (end_addr >= start_addr);

    always_comb begin
        load      = 1'b0;
        load_byte = 8'h00;
        if (can_load) begin
            case (state)
                S_REC_TYPE: begin load = 1'b1; load_byte = CMD_REC_LOAD;                end
                S_REC_LEN:  begin load = 1'b1; load_byte = cmd_len_byte(rec_left[7:0]); end
                S_REC_ALO:  begin load = 1'b1; load_byte = cur[7:0];                    end
                S_REC_AHI:  begin load = 1'b1; load_byte = cur[15:8];                   end
                S_DATA:     begin load = 1'b1; load_byte = rd_byte;                     end
                S_TRL_TYPE: begin load = 1'b1; load_byte = CMD_REC_XFER;                end
                S_TRL_LEN:  begin load = 1'b1; load_byte = 8'h02;                       end
                S_TRL_LO:   begin load = 1'b1; load_byte = exec[7:0];                   end
                S_TRL_HI:   begin load = 1'b1; load_byte = exec[15:8];                  end
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cur        <= 16'h0000;
            exec       <= 16'h0000;
            rec_left   <= 17'd0;
            total_left <= 17'd0;
            lat_cnt    <= 3'd0;
            rd_byte    <= 8'h00;
            mem_addr   <= 16'h0000;
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (end_addr < start_addr) begin
                            error <= 1'b1;
                        end else begin
                            cur        <= start_addr;
                            exec       <= exec_addr;
                            total_left <= {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
                            busy       <= 1'b1;
                            state      <= S_REC_TYPE;
                        end
                    end
                end
                S_REC_TYPE: if (load) begin
                    rec_left <= (total_left < BLK) ? total_left : BLK;
                    state    <= S_REC_LEN;
                end
                S_REC_LEN: if (load) state <= S_REC_ALO;
                S_REC_ALO: if (load) state <= S_REC_AHI;
                S_REC_AHI: if (load) state <= S_RD_REQ;
                // Read only once the previous byte has left, so reads stall with the sink.
                S_RD_REQ: if (!out_valid) begin
                    mem_addr <= cur;
                    mem_rd   <= 1'b1;
                    lat_cnt  <= 3'd0;
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (lat_cnt == LAT) begin
                        rd_byte <= mem_data;
                        state   <= S_DATA;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_DATA: if (load) begin
                    cur        <= cur + 16'd1;
                    rec_left   <= rec_left - 17'd1;
                    total_left <= total_left - 17'd1;
                    if (rec_left == 17'd1) begin
                        state <= (total_left == 17'd1) ? S_TRL_TYPE : S_REC_TYPE;
                    end else begin
                        state <= S_RD_REQ;
                    end
                end
                S_TRL_TYPE: if (load) state <= S_TRL_LEN;
                S_TRL_LEN:  if (load) state <= S_TRL_LO;
                S_TRL_LO:   if (load) state <= S_TRL_HI;
                S_TRL_HI:   if (load) state <= S_FINISH;
                S_FINISH: if (can_load) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    cmd_byte_pipe u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (accept),
        .load      (load),
        .load_data (load_byte),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .can_load  (can_load)
    );

endmodule
